// File: rtl/pool_stream.sv
// Streaming non-overlapping KxK max/average pooling over raster-scan pixels.
// Each channel lane holds one row of partial window results; there is a single output register.

module pool_lane #(
  parameter int DATA_W = 45,
  parameter int ACC_W  = 47,
  parameter int SH     = 2,
  parameter int DEPTH  = 12,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  idx,
  input  logic              first,
  input  logic              avg,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] result
);
  logic [ACC_W-1:0] acc_q [DEPTH];
  logic [ACC_W-1:0] stored, ext, nxt;

  // The entry is read and written back within the same beat, so the next beat
  // to the same entry already sees the combined value.
  assign stored = acc_q[idx];

  always_comb begin
    ext = ACC_W'(sample);
    nxt = stored;
    if (first)             nxt = ext;
    else if (avg)          nxt = stored + ext;
    else if (ext > stored) nxt = ext;
    result = avg ? DATA_W'(nxt >> SH) : DATA_W'(nxt);
  end

  always_ff @(posedge clk)
    if (wr_en) acc_q[idx] <= nxt;
endmodule

module pool_stream #(
  parameter int DATA_W = 45,
  parameter int CH     = 8,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24,
  parameter int K      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*DATA_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*DATA_W-1:0] out_data,
  output logic                 out_last,
  output logic                 frame_done
);
  localparam int OUT_W = IMG_W / K;
  localparam int OUT_H = IMG_H / K;
  localparam int LOGK  = (K == 4) ? 2 : 1;
  localparam int ACC_W = DATA_W + 2*LOGK;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  if (K != 2 && K != 4) begin : g_bad_k
    $error("pool_stream: K must be 2 or 4");
  end

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          mode_q;
  logic          in_fire, out_fire, frame_start, avg_eff;
  logic          in_win, win_first, win_last, emit, last_win;
  logic [CH-1:0][DATA_W-1:0] lane_in, lane_res;

  assign lane_in     = in_data;
  assign in_ready    = !out_valid || out_ready;
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign frame_start = (col == '0) && (row == '0);
  // The first beat of a frame uses the live mode; the rest use the latched copy.
  assign avg_eff     = frame_start ? mode : mode_q;

  assign in_win    = ({1'b0, col} < (CW+1)'(OUT_W*K)) && ({1'b0, row} < (RW+1)'(OUT_H*K));
  assign win_first = (col[LOGK-1:0] == '0) && (row[LOGK-1:0] == '0);
  assign win_last  = (&col[LOGK-1:0]) && (&row[LOGK-1:0]);
  assign emit      = in_fire && in_win && win_last;
  assign last_win  = ((col >> LOGK) == CW'(OUT_W-1)) && ((row >> LOGK) == RW'(OUT_H-1));

  for (genvar c = 0; c < CH; c++) begin : g_lane
    pool_lane #(
      .DATA_W(DATA_W), .ACC_W(ACC_W), .SH(2*LOGK), .DEPTH(OUT_W), .IDX_W(IDX_W)
    ) u_lane (
      .clk   (clk),
      .wr_en (in_fire && in_win),
      .idx   (IDX_W'(col >> LOGK)),
      .first (win_first),
      .avg   (avg_eff),
      .sample(lane_in[c]),
      .result(lane_res[c])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col    <= '0;
      row    <= '0;
      mode_q <= 1'b0;
    end else if (in_fire) begin
      if (frame_start) mode_q <= mode;
      if (col == CW'(IMG_W-1)) begin
        col <= '0;
        row <= (row == RW'(IMG_H-1)) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // A completing beat can only fire when the register is empty or draining,
  // so reloading here never overwrites an unaccepted result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_fire && out_last;
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= lane_res;
        out_last  <= last_win;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pool_stream.sv
// Randomized and directed checks of pool_stream against a window-level pooling model.
module tb_pool_stream;
  localparam int DW   = 45;
  localparam int NONE = 1000;

  typedef struct packed { logic [2*DW-1:0] d; logic last; } exp_t;

  logic clk = 1'b0, rst = 1'b1, mode = 1'b0, ordy = 1'b1;
  logic [2:0] iv = '0;
  logic [2*DW-1:0] din = '0;
  logic [2:0] ir, ov, ol, fd;
  logic [2*DW-1:0] oa;
  logic [DW-1:0] ob, oc;
  logic [1:0] sel = 2'd0;
  logic cur_ir, cur_ov, cur_ol, cur_fd;
  logic [2*DW-1:0] cur_od;

  int total = 0, bad = 0;
  exp_t expq[$];
  logic exp_ov = 1'b0, exp_fd = 1'b0, stall = 1'b0, hold_l = 1'b0;
  logic [2*DW-1:0] hold_d = '0;
  logic [DW-1:0] px [2][64];

  always #5 clk = ~clk;

  pool_stream #(.DATA_W(DW), .CH(2), .IMG_W(4), .IMG_H(4), .K(2)) u_a (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(din),
    .out_valid(ov[0]), .out_ready(ordy), .out_data(oa), .out_last(ol[0]), .frame_done(fd[0]));
  pool_stream #(.DATA_W(DW), .CH(1), .IMG_W(5), .IMG_H(4), .K(2)) u_b (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(din[DW-1:0]),
    .out_valid(ov[1]), .out_ready(ordy), .out_data(ob), .out_last(ol[1]), .frame_done(fd[1]));
  pool_stream #(.DATA_W(DW), .CH(1), .IMG_W(8), .IMG_H(8), .K(4)) u_c (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(din[DW-1:0]),
    .out_valid(ov[2]), .out_ready(ordy), .out_data(oc), .out_last(ol[2]), .frame_done(fd[2]));

  always_comb begin
    cur_ir = ir[sel];
    cur_ov = ov[sel];
    cur_ol = ol[sel];
    cur_fd = fd[sel];
    case (sel)
      2'd0:    cur_od = oa;
      2'd1:    cur_od = {{DW{1'b0}}, ob};
      default: cur_od = {{DW{1'b0}}, oc};
    endcase
  end

  task automatic chk1(input string tag, input logic obs, input logic ex);
    total++;
    assert (obs === ex) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, ex);
    end
  endtask

  task automatic chkd(input string tag, input logic [2*DW-1:0] obs, input logic [2*DW-1:0] ex);
    total++;
    assert (obs === ex) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, ex);
    end
  endtask

  // Expected pooled pixels, window by window in raster order.
  task automatic build_model(input int w, input int h, input int k, input int nch, input logic avg);
    exp_t e;
    longint unsigned acc, v;
    expq.delete();
    for (int wr = 0; wr < h/k; wr++)
      for (int wc = 0; wc < w/k; wc++) begin
        e.d = '0;
        e.last = (wr == h/k-1) && (wc == w/k-1);
        for (int c = 0; c < nch; c++) begin
          acc = 0;
          for (int y = 0; y < k; y++)
            for (int x = 0; x < k; x++) begin
              v = px[c][(wr*k+y)*w + wc*k + x];
              if (avg) acc += v;
              else if (v > acc) acc = v;
            end
          if (avg) acc = acc / longint'(k*k);
          e.d[c*DW +: DW] = acc[DW-1:0];
        end
        expq.push_back(e);
      end
  endtask

  task automatic step(input logic v, input logic [2*DW-1:0] d, input logic md_in, input logic r,
                      input logic cmpl, output bit took);
    exp_t e;
    logic acc_o;
    @(negedge clk);
    iv = '0;
    iv[sel] = v;
    din = d;
    mode = md_in;
    ordy = r;
    #1;
    chk1("out_valid", cur_ov, exp_ov);
    if (stall) begin
      chkd("hold_data", cur_od, hold_d);
      chk1("hold_last", cur_ol, hold_l);
    end
    chk1("in_ready", cur_ir, !exp_ov || r);
    chk1("frame_done", cur_fd, exp_fd);
    acc_o = exp_ov && r;
    exp_fd = 1'b0;
    if (acc_o) begin
      total++;
      assert (expq.size() != 0) else begin
        bad++;
        $error("FAIL extra_out: got data %h want no output", cur_od);
      end
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chkd("out_data", cur_od, e.d);
        chk1("out_last", cur_ol, e.last);
        exp_fd = e.last;
      end
    end
    took = v && (!exp_ov || r);
    stall = exp_ov && !r;
    hold_d = cur_od;
    hold_l = cur_ol;
    if (took && cmpl) exp_ov = 1'b1;
    else if (acc_o)   exp_ov = 1'b0;
  endtask

  task automatic run_frame(input logic [1:0] s, input int w, input int h, input int k, input int nch,
                           input logic md, input int tog_at, input int rdy_pat, input bit gaps,
                           input int nbeats);
    int b, cyc, cl, rw;
    logic v, r, pend, cmpl;
    bit took;
    logic [2*DW-1:0] d;
    sel = s;
    build_model(w, h, k, nch, md);
    b = 0; cyc = 0; pend = 1'b0;
    while ((b < nbeats || (nbeats == w*h && expq.size() != 0)) && cyc < 3000) begin
      v = 1'b0; cmpl = 1'b0; d = '0;
      if (b < nbeats) begin
        v = pend || !gaps || ($urandom_range(0, 3) != 0);
        cl = b % w;
        rw = b / w;
        cmpl = (cl < (w/k)*k) && (rw < (h/k)*k) && (cl % k == k-1) && (rw % k == k-1);
        for (int c = 0; c < nch; c++) d[c*DW +: DW] = px[c][b];
      end
      case (rdy_pat)
        0:       r = 1'b1;
        1:       r = (cyc % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      step(v, d, (b < tog_at) ? md : ~md, r, cmpl, took);
      pend = v && !took;
      if (took) b++;
      cyc++;
    end
    total++;
    assert (cyc < 3000) else begin
      bad++;
      $error("FAIL timeout: got %0d cycles (%0d beats) want under 3000", cyc, b);
    end
    if (nbeats == w*h) step(1'b0, '0, md, 1'b1, 1'b0, took);
  endtask

  task automatic fill_idx(input int n);
    for (int b = 0; b < n; b++) begin
      px[0][b] = DW'(b);
      px[1][b] = DW'(2*b);
    end
  endtask

  task automatic fill_rand(input int n);
    logic [63:0] r64;
    for (int c = 0; c < 2; c++)
      for (int b = 0; b < n; b++) begin
        r64 = {$urandom, $urandom};
        px[c][b] = r64[DW-1:0];
      end
  endtask

  initial begin
    logic [DW-1:0] maxv;
    maxv = '1;
    #12;
    chk1("rst_valid", cur_ov, 1'b0);
    chkd("rst_data", cur_od, '0);
    chk1("rst_last", cur_ol, 1'b0);
    chk1("rst_frame_done", cur_fd, 1'b0);
    chk1("rst_in_ready", cur_ir, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // 4x4, two channels: max, average, backpressure, random data
    fill_idx(16);
    run_frame(2'd0, 4, 4, 2, 2, 1'b0, NONE, 0, 1'b0, 16);
    run_frame(2'd0, 4, 4, 2, 2, 1'b1, NONE, 0, 1'b0, 16);
    run_frame(2'd0, 4, 4, 2, 2, 1'b0, NONE, 1, 1'b0, 16);
    run_frame(2'd0, 4, 4, 2, 2, 1'b0, NONE, 2, 1'b1, 16);
    for (int i = 0; i < 4; i++) begin
      fill_rand(16);
      run_frame(2'd0, 4, 4, 2, 2, 1'(i % 2), NONE, 2, 1'b1, 16);
    end

    // mode changes mid-frame are ignored
    fill_idx(16);
    run_frame(2'd0, 4, 4, 2, 2, 1'b0, 3, 0, 1'b0, 16);
    run_frame(2'd0, 4, 4, 2, 2, 1'b1, 5, 2, 1'b0, 16);

    // asynchronous reset between clock edges, mid-frame
    run_frame(2'd0, 4, 4, 2, 2, 1'b0, NONE, 0, 1'b0, 6);
    @(negedge clk);
    chk1("pre_rst_valid", cur_ov, exp_ov);
    #2;
    rst = 1'b1;
    iv = '0;
    #1;
    chk1("midrst_valid", cur_ov, 1'b0);
    chkd("midrst_data", cur_od, '0);
    chk1("midrst_last", cur_ol, 1'b0);
    chk1("midrst_in_ready", cur_ir, 1'b1);
    expq.delete();
    exp_ov = 1'b0; exp_fd = 1'b0; stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_frame(2'd0, 4, 4, 2, 2, 1'b0, NONE, 0, 1'b0, 16);

    // 5x4 frame: column 4 is cropped
    fill_idx(20);
    run_frame(2'd1, 5, 4, 2, 1, 1'b0, NONE, 0, 1'b0, 20);
    fill_rand(20);
    run_frame(2'd1, 5, 4, 2, 1, 1'b1, NONE, 2, 1'b1, 20);

    // K=4 on 8x8: single full-scale pixel, then all full-scale average
    for (int b = 0; b < 64; b++) px[0][b] = DW'(1);
    px[0][6*8+5] = maxv;
    run_frame(2'd2, 8, 8, 4, 1, 1'b0, NONE, 0, 1'b0, 64);
    for (int b = 0; b < 64; b++) px[0][b] = maxv;
    run_frame(2'd2, 8, 8, 4, 1, 1'b1, NONE, 2, 1'b0, 64);
    fill_rand(64);
    run_frame(2'd2, 8, 8, 4, 1, 1'b1, NONE, 2, 1'b1, 64);
    run_frame(2'd2, 8, 8, 4, 1, 1'b0, NONE, 1, 1'b0, 64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pool_stream.md
Name: pool_stream

Overview:
- Streaming, parametrised successor to the frame-parallel pooling layer.
- Accepts one raster-scan pixel per handshake; each pixel carries CH channels packed side by side.
- Performs non-overlapping KxK max or average pooling using a one-row partial-result buffer instead of whole-frame arrays.
- Sits between the ReLU stage and the next conv/FC stage, with valid/ready on both sides.

Parameters:
- DATA_W, 45: unsigned width of each channel sample.
- CH, 8: number of channels per pixel.
- IMG_W, 24: input frame width in pixels.
- IMG_H, 24: input frame height in pixels.
- K, 2: window size and stride. Legal values are 2 and 4; any other value is an elaboration error.
- OUT_W, IMG_W/K (derived, not overridable): output width.
- OUT_H, IMG_H/K (derived, not overridable): output height.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- mode  in  1  pooling mode: 0 = max, 1 = average. Sampled only at frame start.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept an input pixel.
- in_data  in  CH*DATA_W  pixel data; channel c occupies bits [c*DATA_W +: DATA_W].
- out_valid  out  1  pooled pixel valid.
- out_ready  in  1  downstream accepts the pooled pixel.
- out_data  out  CH*DATA_W  pooled pixel, packed the same way as in_data.
- out_last  out  1  marks the final pooled pixel of a frame.
- frame_done  out  1  one-cycle pulse when the out_last beat is accepted.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_last=0, frame_done=0, all counters=0, latched mode=0. in_ready=1 immediately after reset.
- Handshakes:
  - Input beat transfers when in_valid && in_ready.
  - Output beat transfers when out_valid && out_ready.
  - in_ready = !out_valid || out_ready; there is a single output register.
  - out_data and out_last are held stable while out_valid && !out_ready.
- Counters:
  - col (0..IMG_W-1) and row (0..IMG_H-1) advance on each input beat.
  - col wraps to 0 with row+1; row wraps to 0 at frame end.
  - Window position: wc = col/K, wr = row/K; in-window offsets are col%K and row%K.
- Mode latch: mode is captured on the accepted beat at col=0, row=0 and used for the whole frame. Changes to mode mid-frame are ignored.
- Cropping: beats with col >= OUT_W*K or row >= OUT_H*K are accepted and counted but do not touch the buffer and produce no output.
- Partial buffer: OUT_W entries, each CH x ACC_W, where ACC_W = DATA_W + 2*log2(K).
  - A beat at offset (0,0) of its window loads the entry with the zero-extended sample.
  - Any other offset combines into the entry: max keeps the larger value (unsigned compare, ties keep the stored value); average adds.
- Emission: on the beat at offset (K-1,K-1) of a window, compute the combined value and load the output register at the next edge.
  - Max result: the lower DATA_W bits.
  - Average result: sum >> (2*log2(K)), truncating toward zero.
  - out_valid rises 1 cycle after the completing input beat.
  - out_last=1 for window (OUT_W-1, OUT_H-1).
- Throughput: one input beat per cycle with no bubbles while out_ready=1.
- Simultaneous events:
  - An output accept and a new completing input in the same cycle: the register reloads with the new result and out_valid stays 1.
  - Same-entry read-modify-write across back-to-back beats must forward correctly, i.e. no stale reads.
- frame_done pulses for one cycle on the accepted out_last beat.
- Reset mid-frame clears counters, the latched mode and the output register. Buffer contents need not clear, since each window's first beat reloads its entry.

Test Plan:
- Max mode: IMG 4x4, CH=1, K=2, pixels equal to their raster index 0..15, out_ready=1 -> outputs 5, 7, 13, 15; out_last on 15; frame_done 1 cycle after the last accept.
- Average mode, same stimulus -> outputs 2, 4, 10, 12 (truncation check); second channel fed 2x the values -> outputs 5, 9, 21, 25.
- Backpressure: max run with out_ready toggled 1010... and randomly -> same 4 values, data stable while stalled, in_ready=0 only when out_valid && !out_ready, no beat lost.
- Cropping: IMG_W=5, IMG_H=4, pixels 0..19, max -> outputs 6, 8, 16, 18 only; col 4 beats accepted, produce nothing.
- Mode latch: mode=0 at frame start, toggle to 1 mid-frame -> frame pools max; next frame starting with mode=1 pools average.
- Async reset asserted mid-frame (after 6 beats, not on a clock edge) -> outputs go to 0 immediately; a fresh 4x4 frame afterwards yields 5, 7, 13, 15.
- K=4, IMG 8x8, all 1s except a single 45-bit max value at (5,6) -> max output 1 for windows (0,0), (0,1), (1,0) and the max value for window (1,1), with no overflow; average with all pixels at the max value -> the max value, confirming the ACC_W headroom.
